// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam int NROWS = 4;
    localparam int NCOLS = 4;

    // Classification of an active-low 4-line pattern.
    typedef struct packed {
        logic       idle;    // no line pulled low
        logic       single;  // exactly one line low
        logic [1:0] idx;     // index of the low line when single
    } line_info_t;

    // Decode an active-low pattern into idle/single flags and the low-line index.
    // Patterns with two or more low lines report idle=0, single=0 (multi).
    function automatic line_info_t onehot0_idx(input logic [3:0] lines_n);
        line_info_t info;
        info = '0;
        case (lines_n)
            4'b1111: info.idle = 1'b1;
            4'b1110: begin info.single = 1'b1; info.idx = 2'd0; end
            4'b1101: begin info.single = 1'b1; info.idx = 2'd1; end
            4'b1011: begin info.single = 1'b1; info.idx = 2'd2; end
            4'b0111: begin info.single = 1'b1; info.idx = 2'd3; end
            default: info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones
// so idle (pulled-up) lines read as inactive straight out of reset.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] q_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= '1;
            q_r    <= '1;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column low at a time, reads rows
// back, debounces press and release on the shared 1 ms enable, and emits a
// one-cycle strobe with the key code plus a shift register of recent codes.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce1ms,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] dat
);

    localparam int            CW       = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_MS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [3:0]    rs_s;
    line_info_t    rs_info_s;

    state_t        state_r,     state_nx_s;
    logic [CW-1:0] cnt_r,       cnt_nx_s;
    logic [1:0]    col_idx_r,   col_idx_nx_s;
    logic [3:0]    col_r,       col_nx_s;
    logic [3:0]    prow_r,      prow_nx_s;
    logic [1:0]    pcol_r,      pcol_nx_s;
    logic [3:0]    key_r,       key_nx_s;
    logic          key_valid_r, key_valid_nx_s;
    logic          key_held_r,  key_held_nx_s;
    logic [15:0]   dat_r,       dat_nx_s;

    logic [CW-1:0] cnt_inc_s;
    logic [3:0]    key_new_s;

    sync2 #(.WIDTH(NROWS)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (rs_s)
    );

    assign rs_info_s = onehot0_idx(rs_s);
    // Saturating increment: the counter never wraps even if left running.
    assign cnt_inc_s = (cnt_r == CNT_DONE) ? cnt_r : cnt_r + CNT_ONE;
    // Only used while rs still equals prow, so rs's row index is prow's.
    assign key_new_s = {rs_info_s.idx, pcol_r};

    // Next-state, counter, column and output decisions; updates only on ce1ms.
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        col_idx_nx_s   = col_idx_r;
        prow_nx_s      = prow_r;
        pcol_nx_s      = pcol_r;
        key_nx_s       = key_r;
        key_valid_nx_s = 1'b0;
        key_held_nx_s  = key_held_r;
        dat_nx_s       = dat_r;
        if (ce1ms) begin
            case (state_r)
                SCAN: begin
                    if (rs_info_s.single) begin
                        prow_nx_s  = rs_s;
                        pcol_nx_s  = col_idx_r;
                        cnt_nx_s   = CNT_ONE;
                        state_nx_s = DEBOUNCE;
                    end else begin
                        col_idx_nx_s = col_idx_r + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (rs_s == prow_r) begin
                        if (cnt_inc_s == CNT_DONE) begin
                            cnt_nx_s       = '0;
                            state_nx_s     = HELD;
                            key_nx_s       = key_new_s;
                            dat_nx_s       = {dat_r[11:0], key_new_s};
                            key_valid_nx_s = 1'b1;
                            key_held_nx_s  = 1'b1;
                        end else begin
                            cnt_nx_s = cnt_inc_s;
                        end
                    end else begin
                        cnt_nx_s     = '0;
                        col_idx_nx_s = col_idx_r + 2'd1;
                        state_nx_s   = SCAN;
                    end
                end
                HELD: begin
                    if (rs_info_s.idle) begin
                        if (cnt_inc_s == CNT_DONE) begin
                            cnt_nx_s      = '0;
                            key_held_nx_s = 1'b0;
                            col_idx_nx_s  = col_idx_r + 2'd1;
                            state_nx_s    = SCAN;
                        end else begin
                            cnt_nx_s = cnt_inc_s;
                        end
                    end else begin
                        cnt_nx_s = '0;
                    end
                end
                default: begin
                    cnt_nx_s      = '0;
                    col_idx_nx_s  = 2'd0;
                    key_held_nx_s = 1'b0;
                    state_nx_s    = SCAN;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
        col_nx_s = ~(4'b0001 << col_idx_nx_s);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= SCAN;
            cnt_r       <= '0;
            col_idx_r   <= 2'd0;
            col_r       <= 4'b1110;
            prow_r      <= 4'hF;
            pcol_r      <= 2'd0;
            key_r       <= 4'h0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            dat_r       <= 16'h0000;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            col_idx_r   <= col_idx_nx_s;
            col_r       <= col_nx_s;
            prow_r      <= prow_nx_s;
            pcol_r      <= pcol_nx_s;
            key_r       <= key_nx_s;
            key_valid_r <= key_valid_nx_s;
            key_held_r  <= key_held_nx_s;
            dat_r       <= dat_nx_s;
        end
    end

    assign col       = col_r;
    assign key       = key_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;
    assign dat       = dat_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a physical keypad model (pressed-key
// set crossed with the driven column) feeds the rows, and expectations come
// from a key-history model of accepted codes and scan position.
module tb_keypad_scan;

    localparam int DEB = 4;

    logic        clk;
    logic        rst;
    logic        ce1ms;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic [15:0] dat;

    logic [15:0] pressed;
    int          n_checks;
    int          n_fail;
    int          valid_cnt;
    int          dbl_cnt;
    logic        prev_v;
    int          ce_div;

    // model of accepted history
    logic [15:0] dat_m;
    logic [3:0]  key_m;

    keypad_scan #(.DEBOUNCE_MS(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce1ms     (ce1ms),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held),
        .dat       (dat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 1 ms enable: one clock high out of every ten
    initial begin
        ce1ms  = 1'b0;
        ce_div = 0;
        forever begin
            @(negedge clk);
            ce_div = (ce_div == 9) ? 0 : ce_div + 1;
            ce1ms  = (ce_div == 9);
        end
    end

    // keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && (col[c] == 1'b0)) row[r] = 1'b0;
            end
        end
    end

    // strobe monitor
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            valid_cnt <= valid_cnt + 1;
            if (prev_v) dbl_cnt <= dbl_cnt + 1;
        end
        prev_v <= (key_valid === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] colpat(input int c);
        logic [3:0] p;
        p = 4'b0001 << c;
        return ~p;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // wait for the next ce1ms clock edge, then sample just after it
    task automatic tick();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (ce1ms) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("tick_timeout", 16'(got), 16'd1);
        #1;
    endtask

    task automatic wait_col(input int c);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (col === colpat(c)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_col", 16'(found), 16'd1);
    endtask

    // clean press of one key, held DEB+extra ticks, then clean release
    task automatic press_key(input int code, input int extra);
        int c;
        int v0;
        c = code % 4;
        wait_col(c);
        v0 = valid_cnt;
        pressed[code] = 1'b1;
        for (int t = 1; t <= DEB; t++) begin
            tick();
            if (t < DEB) begin
                chk("dbnc_no_valid", 16'(key_valid), 16'd0);
                chk("dbnc_col_frozen", 16'(col), 16'(colpat(c)));
            end
        end
        key_m = 4'(code);
        dat_m = {dat_m[11:0], key_m};
        chk("press_valid", 16'(key_valid), 16'd1);
        chk("press_key", 16'(key), 16'(key_m));
        chk("press_dat", dat, dat_m);
        chk("press_held", 16'(key_held), 16'd1);
        @(posedge clk);
        #1;
        chk("valid_one_cycle", 16'(key_valid), 16'd0);
        for (int t = 0; t < extra; t++) begin
            tick();
            chk("hold_held", 16'(key_held), 16'd1);
            chk("hold_col_frozen", 16'(col), 16'(colpat(c)));
        end
        chk("hold_one_valid", 16'(valid_cnt - v0), 16'd1);
        pressed[code] = 1'b0;
        for (int t = 1; t <= DEB; t++) begin
            tick();
            if (t < DEB) chk("release_still_held", 16'(key_held), 16'd1);
        end
        chk("release_held_drop", 16'(key_held), 16'd0);
        chk("release_col_rot", 16'(col), 16'(colpat((c + 1) % 4)));
        chk("release_no_repeat", 16'(valid_cnt - v0), 16'd1);
    endtask

    initial begin
        int v0;
        int ci;
        int code;
        n_checks  = 0;
        n_fail    = 0;
        valid_cnt = 0;
        dbl_cnt   = 0;
        prev_v    = 1'b0;
        pressed   = 16'h0000;
        dat_m     = 16'h0000;
        key_m     = 4'h0;
        rst       = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_col", 16'(col), 16'h000E);
        chk("rst_dat", dat, 16'h0000);
        chk("rst_key", 16'(key), 16'h0000);
        chk("rst_valid", 16'(key_valid), 16'd0);
        chk("rst_held", 16'(key_held), 16'd0);
        rst = 1'b1;

        // idle scanning: one column step per tick, wrapping 3 -> 0
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk("scan_rotate", 16'(col), 16'(colpat(t % 4)));
        end

        // clean press of key 9 (row 2, column 1), pressed ~10 ms
        press_key(9, 6);
        chk("key9_dat", dat, 16'h0009);

        // bouncing key 0: no strobe while toggling, then one stable acceptance
        wait_col(0);
        v0 = valid_cnt;
        for (int i = 0; i < 6; i++) begin
            pressed[0] = (i % 2 == 0);
            tick();
            chk("bounce_no_valid", 16'(key_valid), 16'd0);
        end
        pressed[0] = 1'b0;
        chk("bounce_cnt", 16'(valid_cnt - v0), 16'd0);
        press_key(0, 1);
        chk("bounce_key0", 16'(key), 16'h0000);

        // sequence 1, 2, 3, F
        v0 = valid_cnt;
        press_key(1, 0);
        press_key(2, 1);
        press_key(3, 2);
        press_key(15, 0);
        chk("seq_dat", dat, 16'h123F);
        chk("seq_pulses", 16'(valid_cnt - v0), 16'd4);

        // two keys in column 0 (rows 0 and 1): rejected, scan keeps rotating
        wait_col(0);
        v0 = valid_cnt;
        pressed[0] = 1'b1;
        pressed[4] = 1'b1;
        ci = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            ci = (ci + 1) % 4;
            chk("multi_rotate", 16'(col), 16'(colpat(ci)));
            chk("multi_not_held", 16'(key_held), 16'd0);
        end
        pressed[0] = 1'b0;
        pressed[4] = 1'b0;
        chk("multi_no_valid", 16'(valid_cnt - v0), 16'd0);

        // randomized clean presses checked against the history model
        for (int n = 0; n < 5; n++) begin
            code = int'($urandom_range(0, 15));
            press_key(code, int'($urandom_range(0, 5)));
        end

        // reset two ticks into debounce of key 6
        wait_col(2);
        v0 = valid_cnt;
        pressed[6] = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_col", 16'(col), 16'h000E);
        chk("mid_rst_dat", dat, 16'h0000);
        chk("mid_rst_key", 16'(key), 16'h0000);
        chk("mid_rst_valid", 16'(key_valid), 16'd0);
        chk("mid_rst_held", 16'(key_held), 16'd0);
        pressed[6] = 1'b0;
        dat_m = 16'h0000;
        key_m = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_first_col", 16'(col), 16'(colpat(1)));
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("post_rst_no_valid", 16'(key_valid), 16'd0);
        end
        chk("post_rst_pulses", 16'(valid_cnt - v0), 16'd0);
        chk("post_rst_dat", dat, dat_m);
        chk("no_back_to_back_valid", 16'(dbl_cnt), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
